// File: rtl/sonar_echo_emulator.sv
// sonar_echo_emulator: HC-SR04-style sensor stand-in answering a validated trigger with a programmed-width echo.
// Define SONAR_EMU_TRIG_SYNC_EN to pass trig through a two-flop synchronizer (adds 2 cycles of trig latency).
module sonar_echo_emulator #(
    parameter int MIN_TRIG    = 500,
    parameter int BURST_DELAY = 23000,
    parameter int MAX_ECHO    = 1900000,
    parameter int HOLDOFF     = 500,
    parameter int CW          = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic [CW-1:0] echo_len,
    output logic          echo,
    output logic          busy,
    output logic          done,
    output logic          trig_err
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG_HI = 3'd1;
    localparam logic [2:0] S_BURST   = 3'd2;
    localparam logic [2:0] S_ECHO    = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;
    localparam logic [CW-1:0] MIN_C   = CW'(MIN_TRIG);
    localparam logic [CW-1:0] BURST_C = CW'(BURST_DELAY - 1);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_ECHO);
    localparam logic [CW-1:0] HOLD_C  = CW'(HOLDOFF - 1);

    logic          w_trig_s;
    logic [CW-1:0] w_len_sel;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_len;
    logic          r_trig_q;
    logic          r_echo;
    logic          r_done;
    logic          r_trig_err;

`ifdef SONAR_EMU_TRIG_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], trig};
    end
    assign w_trig_s = r_sync[1];
`else
    assign w_trig_s = trig;
`endif

    // Zero or out-of-range lengths behave like a real sensor seeing no object.
    assign w_len_sel = (echo_len == '0 || echo_len > MAX_C) ? MAX_C : echo_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_trig_q   <= 1'b1;
            r_echo     <= 1'b0;
            r_done     <= 1'b0;
            r_trig_err <= 1'b0;
        end else begin
            r_trig_q   <= w_trig_s;
            r_done     <= 1'b0;
            r_trig_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trig_s && !r_trig_q) begin
                        r_state <= S_TRIG_HI;
                        r_cnt   <= CW'(1);
                    end
                end
                S_TRIG_HI: begin
                    if (w_trig_s) begin
                        r_cnt <= (r_cnt < MIN_C) ? r_cnt + 1'b1 : r_cnt;
                    end else if (r_cnt >= MIN_C) begin
                        r_state <= S_BURST;
                        r_cnt   <= '0;
                        r_len   <= w_len_sel;
                    end else begin
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                        r_trig_err <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (r_cnt == BURST_C) begin
                        r_state <= S_ECHO;
                        r_cnt   <= '0;
                        r_echo  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ECHO: begin
                    if (r_cnt == r_len - 1'b1) begin
                        r_state <= S_HOLDOFF;
                        r_cnt   <= '0;
                        r_echo  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (r_cnt == HOLD_C) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign echo     = r_echo;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign trig_err = r_trig_err;
endmodule

// File: tb/tb_sonar_echo_emulator.sv
// tb_sonar_echo_emulator: directed bench for sonar_echo_emulator using scaled-down timing parameters.
module tb_sonar_echo_emulator;
    localparam int MT = 5;
    localparam int BD = 20;
    localparam int ME = 60;
    localparam int HO = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trig = 1'b0;
    logic [CW-1:0] echo_len = '0;
    logic          echo, busy, done, trig_err;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int n_echo = 0, n_done = 0, n_terr = 0, n_busy = 0;
    int t_rise = 0, t_fall = 0, t_done = 0, t_terr = 0, t_brise = 0, t_bfall = 0;
    bit p_echo = 1'b0, p_busy = 1'b0;
    int t_a, t_e1, b_echo, b_done, b_terr, b_busy;

    sonar_echo_emulator #(
        .MIN_TRIG(MT), .BURST_DELAY(BD), .MAX_ECHO(ME), .HOLDOFF(HO), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .echo_len(echo_len),
        .echo(echo), .busy(busy), .done(done), .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    // Event recorder: cyc is the index of the most recent posedge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (echo === 1'b1 && !p_echo) begin n_echo++; t_rise = cyc; end
        if (echo === 1'b0 && p_echo) t_fall = cyc;
        if (done === 1'b1) begin n_done++; t_done = cyc; end
        if (trig_err === 1'b1) begin n_terr++; t_terr = cyc; end
        if (busy === 1'b1 && !p_busy) t_brise = cyc;
        if (busy === 1'b0 && p_busy) t_bfall = cyc;
        if (busy === 1'b1) n_busy++;
        p_echo = (echo === 1'b1);
        p_busy = (busy === 1'b1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic snap();
        b_echo = n_echo; b_done = n_done; b_terr = n_terr; b_busy = n_busy;
    endtask

    task automatic pulse(input int n);
        trig = 1'b1;
        t_e1 = cyc + 1;
        tick(n);
        trig = 1'b0;
        t_a = cyc + 1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 500) begin tick(1); k++; end
        if (k >= 500) check({tag, "_timeout"}, 1, 0);
    endtask

    task automatic wait_echo(input string tag);
        int k = 0;
        while (echo !== 1'b1 && k < 500) begin tick(1); k++; end
        if (k >= 500) check({tag, "_timeout"}, 1, 0);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 500) begin tick(1); k++; end
        if (k >= 500) check({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        tick(3);
        check("rst_echo", int'(echo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_terr", int'(trig_err), 0);
        rst = 1'b0;
        tick(3);

        // Nominal ranging cycle.
        echo_len = 8'd10;
        snap();
        pulse(MT);
        wait_idle("nom");
        check("nom_busy_rise", t_brise - t_e1, 0);
        check("nom_rise", t_rise - t_a, BD);
        check("nom_width", t_fall - t_rise, 10);
        check("nom_echoes", n_echo - b_echo, 1);
        check("nom_dones", n_done - b_done, 1);
        check("nom_done_t", t_done - t_fall, 0);
        check("nom_busy_fall", t_bfall - t_fall, HO);
        check("nom_terr", n_terr - b_terr, 0);
        tick(3);

        // One cycle short of MIN_TRIG.
        snap();
        pulse(MT - 1);
        tick(4);
        check("short_terr", n_terr - b_terr, 1);
        check("short_terr_t", t_terr - t_a, 0);
        check("short_echo", n_echo - b_echo, 0);
        check("short_busy", int'(busy), 0);
        tick(BD + 5);
        check("short_echo_late", n_echo - b_echo, 0);

        // No-object lengths are capped to MAX_ECHO.
        echo_len = 8'd0;
        pulse(MT);
        wait_idle("len0");
        check("len0_width", t_fall - t_rise, ME);
        tick(2);
        echo_len = 8'd200;
        pulse(MT);
        wait_idle("lenbig");
        check("lenbig_width", t_fall - t_rise, ME);
        tick(2);

        // Retriggers during ECHO and HOLDOFF are ignored.
        echo_len = 8'd10;
        snap();
        pulse(MT);
        wait_echo("re");
        pulse(MT);
        wait_done("re");
        tick(1);
        pulse(MT);
        wait_idle("re");
        tick(BD + 5);
        check("re_echoes", n_echo - b_echo, 1);
        check("re_terr", n_terr - b_terr, 0);
        check("re_width", t_fall - t_rise, 10);
        check("re_busy", int'(busy), 0);

        // echo_len change after acceptance has no effect.
        echo_len = 8'd10;
        pulse(MT);
        tick(5);
        echo_len = 8'd30;
        wait_idle("chg");
        check("chg_width", t_fall - t_rise, 10);
        tick(2);

        // Reset mid-echo truncates the pulse.
        pulse(MT);
        wait_echo("mid");
        tick(3);
        rst = 1'b1;
        tick(1);
        check("mid_echo", int'(echo), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_done", int'(done), 0);
        rst = 1'b0;
        tick(2);

        // trig held high through reset release must be seen low first.
        trig = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        snap();
        tick(MT + 5);
        trig = 1'b0;
        tick(3);
        check("hold_busy", n_busy - b_busy, 0);
        check("hold_terr", n_terr - b_terr, 0);
        echo_len = 8'd7;
        pulse(MT);
        wait_idle("post");
        check("post_rise", t_rise - t_a, BD);
        check("post_width", t_fall - t_rise, 7);
        check("post_echoes", n_echo - b_echo, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
